// File: rtl/int_ctrl.sv
// Interrupt controller: fixed-priority arbitration of four level requesters,
// entry at instruction boundaries, and the IRX/IRY shadow status and return address.
module int_ctrl #(
    parameter logic [15:0] VECBASE = 16'hFF00
) (
    input  logic        clk,
    input  logic        nclr,
    input  logic [3:0]  irq,
    input  logic        ibound,
    input  logic [15:0] pc,
    input  logic        ei,
    input  logic        di,
    input  logic        rti,
    input  logic        mask_wr,
    input  logic [3:0]  mask_d,
    output logic        ienabled,
    output logic        istatus,
    output logic [15:0] intRA,
    output logic        take,
    output logic [15:0] vector,
    output logic [3:0]  iack,
    output logic [1:0]  active_id,
    output logic [3:0]  mask
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StEnter  = 2'd1;
    localparam logic [1:0] StActive = 2'd2;
    localparam logic [1:0] StExit   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        ienabled_q, ienabled_d;
    logic [3:0]  mask_q, mask_d_int;
    logic [15:0] ra_q, ra_d;
    logic [1:0]  active_id_q, active_id_d;
    logic        take_q, take_d;
    logic [15:0] vector_q, vector_d;
    logic [3:0]  iack_q, iack_d;

    logic [3:0]  pend;
    logic [1:0]  winner;
    logic        enter;

    // Pending set uses the mask held before this edge, so a mask written on a
    // boundary cycle only affects the following boundary.
    assign pend = irq & mask_q;

    // Lowest set bit wins; scan from the top so the last hit is the lowest.
    always_comb begin
        winner = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pend[i]) begin
                winner = 2'(i);
            end
        end
    end

    assign enter = (state_q == StIdle) && ibound && ienabled_q && (pend != 4'b0000);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (enter) state_d = StEnter;
            StEnter:  state_d = StActive;
            StActive: if (rti) state_d = StExit;
            StExit:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        ienabled_d = ienabled_q;
        if (di) begin
            ienabled_d = 1'b0;
        end else if (ei) begin
            ienabled_d = 1'b1;
        end
    end

    assign mask_d_int = mask_wr ? mask_d : mask_q;

    always_comb begin
        ra_d        = ra_q;
        active_id_d = active_id_q;
        take_d      = 1'b0;
        vector_d    = 16'h0000;
        iack_d      = 4'b0000;
        if (enter) begin
            ra_d        = pc;
            active_id_d = winner;
            take_d      = 1'b1;
            vector_d    = {VECBASE[15:4], winner, 2'b00};
            iack_d      = 4'b0001 << winner;
        end
    end

    always_ff @(posedge clk or negedge nclr) begin
        if (!nclr) begin
            state_q     <= StIdle;
            ienabled_q  <= 1'b0;
            mask_q      <= 4'hF;
            ra_q        <= 16'h0000;
            active_id_q <= 2'd0;
            take_q      <= 1'b0;
            vector_q    <= 16'h0000;
            iack_q      <= 4'b0000;
        end else begin
            state_q     <= state_d;
            ienabled_q  <= ienabled_d;
            mask_q      <= mask_d_int;
            ra_q        <= ra_d;
            active_id_q <= active_id_d;
            take_q      <= take_d;
            vector_q    <= vector_d;
            iack_q      <= iack_d;
        end
    end

    assign ienabled  = ienabled_q;
    assign istatus   = (state_q == StEnter) || (state_q == StActive);
    assign intRA     = (state_q == StIdle) ? pc : ra_q;
    assign take      = take_q;
    assign vector    = vector_q;
    assign iack      = iack_q;
    assign active_id = active_id_q;
    assign mask      = mask_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model.
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        nclr = 1'b0;
    logic [3:0]  irq = 4'h0;
    logic        ibound = 1'b0;
    logic [15:0] pc = 16'h0000;
    logic        ei = 1'b0, di = 1'b0, rti = 1'b0, mask_wr = 1'b0;
    logic [3:0]  mask_d = 4'h0;
    logic        ienabled, istatus, take;
    logic [15:0] intRA, vector;
    logic [3:0]  iack, mask;
    logic [1:0]  active_id;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 = idle, 1 = entering, 2 = in service, 3 = leaving.
    int          m_phase;
    bit          m_en;
    logic [3:0]  m_mask;
    logic [15:0] m_ra;
    logic [1:0]  m_id;
    bit          m_take;
    logic [15:0] m_vec;
    logic [3:0]  m_iack;

    int_ctrl dut (
        .clk(clk), .nclr(nclr), .irq(irq), .ibound(ibound), .pc(pc),
        .ei(ei), .di(di), .rti(rti), .mask_wr(mask_wr), .mask_d(mask_d),
        .ienabled(ienabled), .istatus(istatus), .intRA(intRA), .take(take),
        .vector(vector), .iack(iack), .active_id(active_id), .mask(mask)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_phase = 0; m_en = 0; m_mask = 4'hF; m_ra = 16'h0; m_id = 2'd0;
        m_take = 0; m_vec = 16'h0; m_iack = 4'h0;
    endtask

    task automatic model_step();
        logic [3:0] p;
        int w;
        int nphase;
        p = irq & m_mask;
        nphase = m_phase;
        m_take = 0; m_vec = 16'h0; m_iack = 4'h0;
        if (m_phase == 0) begin
            if (ibound && m_en && p != 0) begin
                w = 0;
                while (!p[w]) w++;
                nphase = 1;
                m_take = 1;
                m_vec  = 16'hFF00 + 16'(4 * w);
                m_iack = 4'(1 << w);
                m_id   = 2'(w);
                m_ra   = pc;
            end
        end else if (m_phase == 1) begin
            nphase = 2;
        end else if (m_phase == 2) begin
            if (rti) nphase = 3;
        end else begin
            nphase = 0;
        end
        m_phase = nphase;
        if (di) m_en = 0;
        else if (ei) m_en = 1;
        if (mask_wr) m_mask = mask_d;
    endtask

    task automatic clear_strobes();
        ibound = 0; ei = 0; di = 0; rti = 0; mask_wr = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        clear_strobes();
    endtask

    task automatic release_reset();
        @(negedge clk);
        nclr = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        pc = 16'hABCD;
        model_reset();
        #12;
        checks++;
        if ({take, iack, vector, istatus, ienabled} !== {1'b0, 4'h0, 16'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_flags got take=%b iack=%h vec=%h ist=%b ien=%b required 0",
                     take, iack, vector, istatus, ienabled);
        end
        checks++;
        if ({mask, active_id} !== {4'hF, 2'd0}) begin
            errors++;
            $display("FAIL reset_mask_id got mask=%h id=%0d required mask=F id=0", mask, active_id);
        end
        checks++;
        if (intRA !== 16'hABCD) begin
            errors++;
            $display("FAIL reset_intra got %h required ABCD", intRA);
        end
        release_reset();
    endtask

    task automatic test_basic_entry();
        ei = 1; tick();
        checks++;
        if (ienabled !== 1'b1) begin
            errors++; $display("FAIL ei_set got %b required 1", ienabled);
        end
        irq = 4'b0100; pc = 16'h1234; ibound = 1; tick();
        checks++;
        if ({take, vector, iack, istatus, intRA, active_id} !==
            {1'b1, 16'hFF08, 4'b0100, 1'b1, 16'h1234, 2'd2}) begin
            errors++;
            $display("FAIL basic_entry got take=%b vec=%h iack=%b ist=%b ra=%h id=%0d",
                     take, vector, iack, istatus, intRA, active_id);
        end
        pc = 16'h5555; #1;
        checks++;
        if (intRA !== 16'h1234) begin
            errors++; $display("FAIL saved_ra got %h required 1234", intRA);
        end
        irq = 4'b0000; tick();
        checks++;
        if ({take, vector, iack, istatus} !== {1'b0, 16'h0, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL active_outs got take=%b vec=%h iack=%b ist=%b", take, vector, iack, istatus);
        end
        rti = 1; tick();
        checks++;
        if ({istatus, intRA} !== {1'b0, 16'h1234}) begin
            errors++; $display("FAIL exit_state got ist=%b ra=%h required 0 1234", istatus, intRA);
        end
        tick();
        checks++;
        if ({istatus, intRA} !== {1'b0, 16'h5555}) begin
            errors++; $display("FAIL back_idle got ist=%b ra=%h required 0 5555", istatus, intRA);
        end
    endtask

    task automatic test_priority();
        irq = 4'b1010; pc = 16'h2000; ibound = 1; tick();
        checks++;
        if ({take, iack, vector, active_id} !== {1'b1, 4'b0010, 16'hFF04, 2'd1}) begin
            errors++;
            $display("FAIL prio_first got take=%b iack=%b vec=%h id=%0d", take, iack, vector, active_id);
        end
        irq = 4'b1000; tick();
        rti = 1; tick();
        ibound = 1; tick();
        checks++;
        if (take !== 1'b0) begin
            errors++; $display("FAIL no_entry_from_exit got take=%b required 0", take);
        end
        tick();
        ibound = 1; tick();
        checks++;
        if ({take, iack, vector, active_id} !== {1'b1, 4'b1000, 16'hFF0C, 2'd3}) begin
            errors++;
            $display("FAIL prio_second got take=%b iack=%b vec=%h id=%0d", take, iack, vector, active_id);
        end
        irq = 4'b0000; tick();
        rti = 1; tick();
        tick();
    endtask

    task automatic test_gating();
        int takes;
        di = 1; tick();
        checks++;
        if (ienabled !== 1'b0) begin
            errors++; $display("FAIL di_clear got %b required 0", ienabled);
        end
        irq = 4'hF;
        takes = 0;
        for (int i = 0; i < 10; i++) begin
            ibound = 1; tick();
            if (take === 1'b1 || istatus === 1'b1) takes++;
        end
        checks++;
        if (takes != 0) begin
            errors++; $display("FAIL disabled_no_take got %0d takes required 0", takes);
        end
        ei = 1; di = 1; tick();
        checks++;
        if (ienabled !== 1'b0) begin
            errors++; $display("FAIL ei_di_same got %b required 0", ienabled);
        end
        ei = 1; tick();
        mask_wr = 1; mask_d = 4'b1110; irq = 4'b0001; tick();
        checks++;
        if (mask !== 4'b1110) begin
            errors++; $display("FAIL mask_write got %b required 1110", mask);
        end
        ibound = 1; tick();
        checks++;
        if (take !== 1'b0) begin
            errors++; $display("FAIL masked_no_take got %b required 0", take);
        end
        ibound = 1; mask_wr = 1; mask_d = 4'hF; tick();
        checks++;
        if ({take, mask} !== {1'b0, 4'hF}) begin
            errors++; $display("FAIL mask_pre_edge got take=%b mask=%h required 0 F", take, mask);
        end
        ibound = 1; tick();
        checks++;
        if ({take, iack} !== {1'b1, 4'b0001}) begin
            errors++; $display("FAIL unmasked_take got take=%b iack=%b required 1 0001", take, iack);
        end
        di = 1; tick();
        checks++;
        if ({istatus, ienabled} !== {1'b1, 1'b0}) begin
            errors++; $display("FAIL di_in_enter got ist=%b ien=%b required 1 0", istatus, ienabled);
        end
        irq = 4'b0000; rti = 1; tick();
        tick();
    endtask

    task automatic test_no_nesting();
        int takes;
        ei = 1; tick();
        irq = 4'b0100; ibound = 1; pc = 16'h3000; tick();
        checks++;
        if (take !== 1'b1) begin
            errors++; $display("FAIL nest_entry got %b required 1", take);
        end
        irq = 4'b0001;
        takes = 0;
        for (int i = 0; i < 3; i++) begin
            ibound = 1; tick();
            if (take !== 1'b0 || istatus !== 1'b1) takes++;
        end
        checks++;
        if (takes != 0) begin
            errors++; $display("FAIL no_nesting got %0d bad cycles required 0", takes);
        end
        irq = 4'b0000; rti = 1; tick();
        checks++;
        if (istatus !== 1'b0) begin
            errors++; $display("FAIL rti_exit got ist=%b required 0", istatus);
        end
        pc = 16'h3456; tick();
        checks++;
        if (intRA !== 16'h3456) begin
            errors++; $display("FAIL rti_idle got ra=%h required 3456", intRA);
        end
        rti = 1; tick();
        checks++;
        if ({istatus, take, intRA} !== {1'b0, 1'b0, 16'h3456}) begin
            errors++;
            $display("FAIL rti_in_idle got ist=%b take=%b ra=%h required 0 0 3456", istatus, take, intRA);
        end
        irq = 4'b0001; ibound = 1; tick();
        checks++;
        if ({take, iack} !== {1'b1, 4'b0001}) begin
            errors++; $display("FAIL still_idle got take=%b iack=%b required 1 0001", take, iack);
        end
        irq = 4'b0000; tick();
        rti = 1; tick();
        tick();
    endtask

    task automatic test_async_reset();
        ei = 1; tick();
        irq = 4'b0010; ibound = 1; tick();
        #2 nclr = 1'b0;
        #1;
        checks++;
        if ({take, iack, vector, istatus} !== {1'b0, 4'h0, 16'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_in_enter got take=%b iack=%b vec=%h ist=%b", take, iack, vector, istatus);
        end
        model_reset(); clear_strobes(); irq = 4'h0;
        release_reset();
        ei = 1; tick();
        irq = 4'b0010; ibound = 1; tick();
        irq = 4'b0000; tick();
        checks++;
        if (istatus !== 1'b1) begin
            errors++; $display("FAIL pre_reset_active got ist=%b required 1", istatus);
        end
        mask_wr = 1; mask_d = 4'h3; tick();
        #2 nclr = 1'b0;
        #1;
        checks++;
        if ({istatus, ienabled, take, mask, active_id} !== {1'b0, 1'b0, 1'b0, 4'hF, 2'd0}) begin
            errors++;
            $display("FAIL reset_in_active got ist=%b ien=%b take=%b mask=%h id=%0d",
                     istatus, ienabled, take, mask, active_id);
        end
        model_reset(); clear_strobes();
        release_reset();
    endtask

    task automatic test_random();
        int bad;
        for (int c = 0; c < 600; c++) begin
            irq     = 4'($urandom);
            pc      = 16'($urandom);
            ibound  = ($urandom_range(0, 1) == 1);
            ei      = ($urandom_range(0, 5) == 0);
            di      = ($urandom_range(0, 11) == 0);
            rti     = ($urandom_range(0, 3) == 0);
            mask_wr = ($urandom_range(0, 7) == 0);
            mask_d  = 4'($urandom);
            tick();
            bad = 0;
            if (take !== m_take) bad++;
            if (vector !== m_vec) bad++;
            if (iack !== m_iack) bad++;
            if (istatus !== (m_phase == 1 || m_phase == 2)) bad++;
            if (ienabled !== m_en) bad++;
            if (mask !== m_mask) bad++;
            if (active_id !== m_id) bad++;
            if (intRA !== ((m_phase == 0) ? pc : m_ra)) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL random cyc %0d got take=%b vec=%h iack=%b ist=%b ien=%b mask=%h id=%0d ra=%h required take=%b vec=%h iack=%b phase=%0d ien=%b mask=%h id=%0d ra=%h",
                         c, take, vector, iack, istatus, ienabled, mask, active_id, intRA,
                         m_take, m_vec, m_iack, m_phase, m_en, m_mask, m_id,
                         (m_phase == 0) ? pc : m_ra);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_entry();
        test_priority();
        test_gating();
        test_no_nesting();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
